data_strobe_tx: RTL and testbench

Transmit side of the data_ready strobe interface. Takes parallel words over a valid/ready handshake and presents each on a held data bus. For each word it drives a data_ready pulse of fixed, parameterised shape: setup time, then high phase, then low phase. The receiving block detects the pulse by synchronising it and finding its rising and falling edges. The block sits between the word source (e.g. hash-candidate generator) and the bus toward the receiving block.

---
 rtl/data_strobe_tx.sv | 97 +++++++++
 tb/tb_data_strobe_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_strobe_tx.sv
// Transmit side of the data_ready strobe interface: accepts a word over valid/ready,
// holds it on data_out and issues one fixed-shape setup/high/low data_ready pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid; data_out keeps last word
// SETUP | word held, data_ready low for SETUP_CYCLES
// HIGH  | data_ready high for HIGH_CYCLES; words_sent bumped on entry
// LOW   | data_ready low for LOW_CYCLES before returning to IDLE
module data_strobe_tx #(
   parameter int DATA_WIDTH   = 32,
   parameter int SETUP_CYCLES = 1,
   parameter int HIGH_CYCLES  = 4,
   parameter int LOW_CYCLES   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_sent
);

   localparam int MAX_SH  = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
   localparam int MAX_CYC = (MAX_SH > LOW_CYCLES) ? MAX_SH : LOW_CYCLES;
   localparam int PW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // Phase counter is loaded with length-1 and the phase ends at terminal count zero.
   localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYCLES - 1);
   localparam logic [PW-1:0] HIGH_LD  = PW'(HIGH_CYCLES - 1);
   localparam logic [PW-1:0] LOW_LD   = PW'(LOW_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   state_t         state;
   logic [PW-1:0]  phase_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         words_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_out  <= in_data;
                  phase_cnt <= SETUP_LD;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (phase_cnt == '0) begin
                  phase_cnt  <= HIGH_LD;
                  data_ready <= 1'b1;
                  words_sent <= words_sent + 1'b1;
                  state      <= HIGH;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            HIGH: begin
               if (phase_cnt == '0) begin
                  phase_cnt  <= LOW_LD;
                  data_ready <= 1'b0;
                  state      <= LOW;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            LOW: begin
               if (phase_cnt == '0) begin
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_strobe_tx.sv
// Self-checking bench for data_strobe_tx: default-parameter instance checked against a
// frame-age reference model, plus a minimal-shape instance for the 1/1/1 and wrap corner.
module tb_data_strobe_tx;

   localparam int S = 1;
   localparam int H = 4;
   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] data_out;
   logic        data_ready;
   logic        busy;
   logic [15:0] words_sent;

   logic        s_rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_in_ready;
   logic [7:0]  s_data_out;
   logic        s_data_ready;
   logic        s_busy;
   logic [1:0]  s_words_sent;

   always #5 clk = ~clk;

   data_strobe_tx dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .data_out(data_out), .data_ready(data_ready), .busy(busy), .words_sent(words_sent)
   );

   data_strobe_tx #(
      .DATA_WIDTH(8), .SETUP_CYCLES(1), .HIGH_CYCLES(1), .LOW_CYCLES(1), .CNT_WIDTH(2)
   ) u_small (
      .clk(clk), .rst(s_rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_in_ready),
      .data_out(s_data_out), .data_ready(s_data_ready), .busy(s_busy), .words_sent(s_words_sent)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference: a frame is just "edges since accept"; outputs are derived from that age.
   bit          m_active = 1'b0;
   int          m_k = 0;
   logic [31:0] m_word = '0;
   logic [15:0] m_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_active = 1'b0; m_k = 0; m_word = '0; m_cnt = '0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active = 1'b1; m_k = 0; m_word = in_data;
         end
      end else begin
         m_k++;
         if (m_k == S) m_cnt = m_cnt + 16'd1;
         if (m_k == S + H + L) m_active = 1'b0;
      end
   endtask

   task automatic step();
      logic exp_dr;
      @(posedge clk);
      model_edge();
      #1;
      exp_dr = m_active && (m_k >= S) && (m_k < S + H);
      check("data_ready", {31'd0, data_ready}, {31'd0, exp_dr});
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_active});
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("data_out", data_out, m_word);
      check("words_sent", {16'd0, words_sent}, {16'd0, m_cnt});
   endtask

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] data;
      logic        dr;
      logic        ir;
      logic        bz;
      logic [31:0] dout;
      logic [15:0] ws;
   } vec_t;

   vec_t tbl [14];

   initial begin
      int rises, hi_len, bound;
      logic prev_dr;
      logic [31:0] words [3];
      int widx;
      int exp_seq [5];
      int seq_i;

      // Reset with in_valid high, then one DEADBEEF frame at default shape.
      for (int i = 0; i < 3; i++)
         tbl[i] = '{1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h0, 16'd0};
      tbl[3] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'd0};
      for (int i = 4; i <= 7; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd1};
      for (int i = 8; i <= 11; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'd1};
      for (int i = 12; i <= 13; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 16'd1};

      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].data;
         step();
         check("tbl_data_ready", {31'd0, data_ready}, {31'd0, tbl[i].dr});
         check("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl[i].ir});
         check("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].bz});
         check("tbl_data_out", data_out, tbl[i].dout);
         check("tbl_words_sent", {16'd0, words_sent}, {16'd0, tbl[i].ws});
      end

      // Back-to-back: in_valid held, the word advances only after each accept.
      words = '{32'h11111111, 32'h22222222, 32'h33333333};
      widx = 0; rises = 0; hi_len = 0; prev_dr = data_ready;
      in_valid = 1'b1; in_data = words[0];
      for (int n = 0; n < 30; n++) begin
         step();
         if (m_active && m_k == 0) begin
            check("b2b_accept_time", n, widx * (S + H + L + 1));
            widx++;
            if (widx < 3) in_data = words[widx];
            else in_valid = 1'b0;
         end
         if (data_ready && !prev_dr) rises++;
         if (data_ready) hi_len++;
         if (!data_ready && prev_dr) begin
            check("b2b_high_len", hi_len, H);
            hi_len = 0;
         end
         prev_dr = data_ready;
      end
      check("b2b_pulses", rises, 3);
      check("b2b_words_sent", {16'd0, words_sent}, 32'd4);

      // Backpressure: data changes every cycle while the frame runs.
      in_valid = 1'b1;
      for (int n = 0; n < 25; n++) begin
         in_data = $urandom;
         step();
      end
      in_valid = 1'b0;
      bound = 0;
      while (m_active && bound < 20) begin step(); bound++; end
      check("idle_bound", {31'd0, m_active}, 32'd0);

      // Mid-frame reset during HIGH, then a fresh full-shape pulse.
      in_valid = 1'b1; in_data = 32'h12345678;
      step();
      in_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      check("midrst_data_ready", {31'd0, data_ready}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_words_sent", {16'd0, words_sent}, 32'd0);
      rst = 1'b0;
      step();
      in_valid = 1'b1; in_data = 32'hCAFEF00D;
      step();
      in_valid = 1'b0;
      rises = 0; hi_len = 0; prev_dr = data_ready;
      for (int n = 0; n < 10; n++) begin
         step();
         if (data_ready && !prev_dr) rises++;
         if (data_ready) hi_len++;
         prev_dr = data_ready;
      end
      check("post_rst_pulses", rises, 1);
      check("post_rst_high_len", hi_len, H);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 60) == 0);
         in_valid = $urandom_range(0, 1) == 1;
         in_data = $urandom;
         step();
      end
      rst = 1'b0; in_valid = 1'b0;

      // Minimal 1/1/1 shape with a 2-bit wrapping counter.
      step();
      check("small_rst_ws", {30'd0, s_words_sent}, 32'd0);
      check("small_rst_ir", {31'd0, s_in_ready}, 32'd1);
      exp_seq = '{1, 2, 3, 0, 1};
      seq_i = 0;
      s_rst = 1'b0; s_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         s_data = 8'(8'h10 + n);
         step();
         check("small_data_ready", {31'd0, s_data_ready}, {31'd0, (n % 4) == 1});
         check("small_in_ready", {31'd0, s_in_ready}, {31'd0, (n % 4) == 3});
         check("small_data_out", {24'd0, s_data_out}, {24'd0, 8'(8'h10 + n - (n % 4))});
         if ((n % 4) == 1 && seq_i < 5) begin
            check("small_ws_seq", {30'd0, s_words_sent}, exp_seq[seq_i]);
            seq_i++;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
